// File: rtl/shared_memory_arbiter_pkg.sv
// Shared definitions for the instruction/data RAM arbiter.
//   arbState_t : arbiter FSM states (IDLE, ACCESS, RESPOND)
//   owner_t    : which requester currently owns the RAM
package shared_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } arbState_t;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_t;

endpackage

// File: rtl/shared_memory_arbiter_starvation_counter.sv
// Saturating counter of consecutive data grants made while fetch waits.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   inc        : count one more data grant (ignored once saturated)
//   clear      : return to zero (wins over inc)
//   atLimit    : count has reached LIMIT; fetch must win the next tie
module starvation_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clear,
  output logic atLimit
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  assign atLimit = (count == CW'(LIMIT));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && !atLimit) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/shared_memory_arbiter.sv
// Shares one single-ported, fixed-latency RAM between instruction fetch and
// the MEM stage. One access at a time; registered return data with a
// one-cycle ready pulse; combinational stall outputs.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   ifRequest/ifAddress           : fetch request (held until ifReady)
//   ifReady/ifData/ifStall        : fetch response pulse, word, stall
//   memRead/memWrite/memAddress/memWriteData : data-side request
//   memReady/memReadData/memStall : data response pulse, load data, stall
//   ramEnable/ramWrite/ramAddress/ramWriteData : registered RAM command
//   ramReadData                   : RAM data, valid MEM_LATENCY after ramEnable
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no access; arbitrate and latch owner/address/op on a grant
// ACCESS  | latCnt=0 cycle strobes the RAM; reads wait for latCnt==MEM_LATENCY
// RESPOND | one-cycle ready pulse to the owner, then back to IDLE
module shared_memory_arbiter
  import shared_memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifRequest,
  input  logic [ADDR_WIDTH-1:0] ifAddress,
  output logic                  ifReady,
  output logic [DATA_WIDTH-1:0] ifData,
  output logic                  ifStall,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [ADDR_WIDTH-1:0] memAddress,
  input  logic [DATA_WIDTH-1:0] memWriteData,
  output logic                  memReady,
  output logic [DATA_WIDTH-1:0] memReadData,
  output logic                  memStall,
  output logic                  ramEnable,
  output logic                  ramWrite,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  output logic [DATA_WIDTH-1:0] ramWriteData,
  input  logic [DATA_WIDTH-1:0] ramReadData
);

  localparam int CNT_WIDTH = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_WIDTH-1:0] LAT_LAST = CNT_WIDTH'(MEM_LATENCY);

  arbState_t state, nextState;
  owner_t owner;
  logic isWrite;
  logic [CNT_WIDTH-1:0] latCnt;

  logic memReq;
  logic grantIf, grantMem;
  logic captureRead;
  logic starveAtLimit;

  assign memReq = memRead | memWrite;

  always_comb begin
    nextState = state;
    grantIf   = 1'b0;
    grantMem  = 1'b0;
    case (state)
      IDLE: begin
        // Data side is older and wins ties unless fetch has been starved.
        if (ifRequest && (!memReq || starveAtLimit)) begin
          grantIf = 1'b1;
        end else if (memReq) begin
          grantMem = 1'b1;
        end
        if (grantIf || grantMem) nextState = ACCESS;
      end
      ACCESS: begin
        if (isWrite || latCnt == LAT_LAST) nextState = RESPOND;
      end
      RESPOND: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign captureRead = (state == ACCESS) && !isWrite && (latCnt == LAT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= OWNER_IF;
      isWrite      <= 1'b0;
      latCnt       <= '0;
      ramEnable    <= 1'b0;
      ramWrite     <= 1'b0;
      ramAddress   <= '0;
      ramWriteData <= '0;
      ifData       <= '0;
      memReadData  <= '0;
    end else begin
      state     <= nextState;
      ramEnable <= grantIf | grantMem;
      ramWrite  <= grantMem & memWrite;
      if (grantIf) begin
        owner      <= OWNER_IF;
        isWrite    <= 1'b0;
        ramAddress <= ifAddress;
      end else if (grantMem) begin
        owner      <= OWNER_MEM;
        isWrite    <= memWrite;
        ramAddress <= memAddress;
        if (memWrite) ramWriteData <= memWriteData;
      end
      if (grantIf || grantMem) begin
        latCnt <= '0;
      end else if (state == ACCESS) begin
        latCnt <= latCnt + 1'b1;
      end
      // A redirected fetch still gets its word captured; only the pulse is dropped.
      if (captureRead) begin
        if (owner == OWNER_IF) ifData <= ramReadData;
        else                   memReadData <= ramReadData;
      end
    end
  end

  // ramAddress still holds the granted fetch address during RESPOND.
  assign ifReady  = (state == RESPOND) && (owner == OWNER_IF) &&
                    ifRequest && (ifAddress == ramAddress);
  assign memReady = (state == RESPOND) && (owner == OWNER_MEM);
  assign ifStall  = ifRequest & ~ifReady;
  assign memStall = memReq & ~memReady;

  starvation_counter #(
    .LIMIT(STARVE_LIMIT)
  ) uStarve (
    .clk    (clk),
    .reset  (reset),
    .inc    (grantMem & ifRequest),
    .clear  (grantIf | (grantMem & ~ifRequest)),
    .atLimit(starveAtLimit)
  );

endmodule

// File: tb/tb_shared_memory_arbiter.sv
module tb_shared_memory_arbiter;

  localparam int L     = 2;
  localparam int LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        ifRequest;
  logic [31:0] ifAddress;
  logic        ifReady;
  logic [31:0] ifData;
  logic        ifStall;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memReady;
  logic [31:0] memReadData;
  logic        memStall;
  logic        ramEnable;
  logic        ramWrite;
  logic [31:0] ramAddress;
  logic [31:0] ramWriteData;
  logic [31:0] ramReadData;

  shared_memory_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .ifRequest(ifRequest), .ifAddress(ifAddress), .ifReady(ifReady),
    .ifData(ifData), .ifStall(ifStall),
    .memRead(memRead), .memWrite(memWrite), .memAddress(memAddress),
    .memWriteData(memWriteData), .memReady(memReady),
    .memReadData(memReadData), .memStall(memStall),
    .ramEnable(ramEnable), .ramWrite(ramWrite), .ramAddress(ramAddress),
    .ramWriteData(ramWriteData), .ramReadData(ramReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // RAM: contents plus a fixed-latency read pipe; junk outside the valid cycle.
  logic [31:0] ramArr [logic [31:0]];
  logic [31:0] rdResp [int];

  function automatic logic [31:0] ramRead(input logic [31:0] a);
    if (ramArr.exists(a)) return ramArr[a];
    return a ^ 32'hA5A50000;
  endfunction

  always @(negedge clk) begin
    if (ramEnable === 1'b1) begin
      if (ramWrite === 1'b1) ramArr[ramAddress] = ramWriteData;
      else rdResp[cyc + L] = ramRead(ramAddress);
    end
  end

  always begin
    @(posedge clk);
    cyc++;
    #1;
    ramReadData = rdResp.exists(cyc) ? rdResp[cyc] : (32'hBAD00000 | 32'(cyc & 16'hFFFF));
  end

  // Transaction-timeline model: a grant at cycle g strobes the RAM at g+1,
  // a load returns at g+L+1 and is reported at g+L+2, a store reports at g+2.
  bit          mBusy = 0;
  int          mAge = 0;
  bit          mOwnIf = 0;
  bit          mWr = 0;
  int          mStarve = 0;
  logic [31:0] mAddr = '0;
  logic [31:0] eIfData = '0, eMemData = '0, eRamAddr = '0, eRamWd = '0;

  always @(negedge clk) begin
    int readyAge;
    bit eEn, eRdy, eIfRdy, eMemRdy, req;
    readyAge = mWr ? 2 : L + 2;
    eEn      = mBusy && mAge == 1;
    eRdy     = mBusy && mAge == readyAge;
    eIfRdy   = eRdy && mOwnIf && ifRequest && (ifAddress == mAddr);
    eMemRdy  = eRdy && !mOwnIf;
    if (started) begin
      chk("model ramEnable", 32'(ramEnable), 32'(eEn));
      chk("model ramWrite", 32'(ramWrite), 32'(eEn && mWr));
      chk("model ramAddress", ramAddress, eRamAddr);
      chk("model ramWriteData", ramWriteData, eRamWd);
      chk("model ifReady", 32'(ifReady), 32'(eIfRdy));
      chk("model memReady", 32'(memReady), 32'(eMemRdy));
      chk("model ifData", ifData, eIfData);
      chk("model memReadData", memReadData, eMemData);
      chk("model ifStall", 32'(ifStall), 32'(ifRequest && !eIfRdy));
      chk("model memStall", 32'(memStall), 32'((memRead || memWrite) && !eMemRdy));
    end
    req = memRead || memWrite;
    if (reset) begin
      mBusy = 0; mAge = 0; mOwnIf = 0; mWr = 0; mStarve = 0; mAddr = '0;
      eIfData = '0; eMemData = '0; eRamAddr = '0; eRamWd = '0;
      started = 1;
    end else if (mBusy) begin
      if (!mWr && mAge == L + 1) begin
        if (mOwnIf) eIfData = ramRead(mAddr);
        else eMemData = ramRead(mAddr);
      end
      if (mAge == readyAge) mBusy = 0;
      else mAge++;
    end else if (ifRequest || req) begin
      mOwnIf = ifRequest && (!req || mStarve >= LIMIT);
      if (mOwnIf) begin
        mStarve = 0;
        mAddr = ifAddress;
        mWr = 0;
      end else begin
        if (ifRequest) begin
          if (mStarve < LIMIT) mStarve++;
        end else begin
          mStarve = 0;
        end
        mAddr = memAddress;
        mWr = memWrite;
        if (memWrite) eRamWd = memWriteData;
      end
      eRamAddr = mAddr;
      mBusy = 1;
      mAge = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic waitMemReady(input string name);
    int n;
    n = 0;
    step(); probe();
    while (memReady !== 1'b1 && n < 20) begin step(); probe(); n++; end
    chk(name, 32'(memReady), 32'd1);
  endtask

  task automatic waitIfReady(input string name);
    int n;
    n = 0;
    step(); probe();
    while (ifReady !== 1'b1 && n < 20) begin step(); probe(); n++; end
    chk(name, 32'(ifReady), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; ifRequest = 0; ifAddress = '0; memRead = 0; memWrite = 0;
    memAddress = '0; memWriteData = '0; ramReadData = '0;
    ramArr[32'h10]  = 32'h00A00093;
    ramArr[32'h20]  = 32'h00200013;
    ramArr[32'h30]  = 32'h00300013;
    ramArr[32'h34]  = 32'h00340013;
    ramArr[32'h40]  = 32'h00400013;
    ramArr[32'h200] = 32'h12345678;
    for (int k = 0; k < 5; k++) ramArr[32'h300 + 32'(4 * k)] = 32'h11110000 + 32'(k);

    // reset state
    step(); step(); probe();
    chk("rst ramEnable", 32'(ramEnable), 32'd0);
    chk("rst ramAddress", ramAddress, 32'h0);
    chk("rst ramWriteData", ramWriteData, 32'h0);
    chk("rst ifData", ifData, 32'h0);
    chk("rst memReadData", memReadData, 32'h0);
    step(); reset = 0; probe();

    // 1: single fetch
    step(); ifRequest = 1; ifAddress = 32'h10; probe();
    chk("t1 ifStall c0", 32'(ifStall), 32'd1);
    step(); probe();
    chk("t1 ramEnable c1", 32'(ramEnable), 32'd1);
    chk("t1 ramAddress c1", ramAddress, 32'h10);
    step(); step(); probe();
    chk("t1 ifStall c3", 32'(ifStall), 32'd1);
    step(); probe();
    chk("t1 ifReady c4", 32'(ifReady), 32'd1);
    chk("t1 ifData c4", ifData, 32'h00A00093);
    chk("t1 ifStall c4", 32'(ifStall), 32'd0);
    step(); ifRequest = 0; probe();

    // 2: tie goes to data side
    step(); ifRequest = 1; ifAddress = 32'h20; memRead = 1; memAddress = 32'h200; probe();
    step(); probe();
    chk("t2 ramAddress c1", ramAddress, 32'h200);
    step(); step(); step(); probe();
    chk("t2 memReady c4", 32'(memReady), 32'd1);
    chk("t2 memReadData c4", memReadData, 32'h12345678);
    step(); memRead = 0; probe();
    step(); probe();
    chk("t2 ramAddress c6", ramAddress, 32'h20);
    step(); step(); step(); probe();
    chk("t2 ifReady c9", 32'(ifReady), 32'd1);
    chk("t2 ifData c9", ifData, 32'h00200013);
    step(); ifRequest = 0; probe();

    // 3: starvation limit
    step(); ifRequest = 1; ifAddress = 32'h30; memRead = 1; memAddress = 32'h300; probe();
    for (int k = 0; k < 4; k++) begin
      waitMemReady($sformatf("t3 memReady %0d", k));
      chk($sformatf("t3 memReadData %0d", k), memReadData, 32'h11110000 + 32'(k));
      step(); memAddress = 32'h300 + 32'(4 * (k + 1)); probe();
    end
    step(); probe();
    chk("t3 fetch wins after limit", ramAddress, 32'h30);
    waitIfReady("t3 ifReady");
    chk("t3 ifData", ifData, 32'h00300013);
    step(); ifAddress = 32'h34; probe();
    step(); probe();
    chk("t3 data wins after clear", ramAddress, 32'h310);
    waitMemReady("t3 memReady 4");
    chk("t3 memReadData 4", memReadData, 32'h11110004);
    step(); memRead = 0; probe();
    waitIfReady("t3 ifReady 34");
    chk("t3 ifData 34", ifData, 32'h00340013);
    step(); ifRequest = 0; probe();

    // 4: stores, read+write treated as store, read-back
    step(); memWrite = 1; memAddress = 32'h100; memWriteData = 32'hDEADBEEF; probe();
    step(); probe();
    chk("t4 ramEnable c1", 32'(ramEnable), 32'd1);
    chk("t4 ramWrite c1", 32'(ramWrite), 32'd1);
    chk("t4 ramAddress c1", ramAddress, 32'h100);
    chk("t4 ramWriteData c1", ramWriteData, 32'hDEADBEEF);
    step(); probe();
    chk("t4 memReady c2", 32'(memReady), 32'd1);
    chk("t4 ifReady c2", 32'(ifReady), 32'd0);
    step(); memRead = 1; memWrite = 1; memAddress = 32'h104; memWriteData = 32'hCAFEF00D; probe();
    step(); probe();
    chk("t4 rw ramWrite", 32'(ramWrite), 32'd1);
    chk("t4 rw ramWriteData", ramWriteData, 32'hCAFEF00D);
    step(); probe();
    chk("t4 rw memReady", 32'(memReady), 32'd1);
    chk("t4 rw memReadData kept", memReadData, 32'h11110004);
    step(); memWrite = 0; memAddress = 32'h100; probe();
    waitMemReady("t4 readback memReady");
    chk("t4 readback data", memReadData, 32'hDEADBEEF);
    step(); memRead = 0; probe();

    // 5: fetch redirect drops the stale word
    step(); ifRequest = 1; ifAddress = 32'h20; probe();
    step(); probe();
    step(); ifAddress = 32'h40; probe();
    step(); probe();
    step(); probe();
    chk("t5 no ifReady c4", 32'(ifReady), 32'd0);
    chk("t5 ifData updated c4", ifData, 32'h00200013);
    step(); probe();
    step(); probe();
    chk("t5 ramAddress c6", ramAddress, 32'h40);
    step(); step(); step(); probe();
    chk("t5 ifReady c9", 32'(ifReady), 32'd1);
    chk("t5 ifData c9", ifData, 32'h00400013);
    step(); ifRequest = 0; probe();

    // 6: reset in the middle of a read
    step(); memRead = 1; memAddress = 32'h308; probe();
    step(); probe();
    step(); reset = 1; probe();
    step(); reset = 0; memRead = 0; probe();
    chk("t6 ramEnable c3", 32'(ramEnable), 32'd0);
    chk("t6 ramAddress c3", ramAddress, 32'h0);
    chk("t6 memReadData c3", memReadData, 32'h0);
    chk("t6 ifData c3", ifData, 32'h0);
    chk("t6 memReady c3", 32'(memReady), 32'd0);
    step(); probe();
    chk("t6 memReady c4", 32'(memReady), 32'd0);
    chk("t6 memReadData c4", memReadData, 32'h0);
    step(); step(); probe();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
